// File: rtl/fb_pkg.sv
// Shared constants, widths and FSM state type for the frame-buffer blit scheduler.
package fb_pkg;

    localparam int FB_W     = 208;
    localparam int FB_H     = 84;
    localparam int FB_DEPTH = FB_W * FB_H;

    localparam int FB_AW  = 15;
    localparam int PIX_W  = 5;
    localparam int ROM_AW = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BLIT,
        DRAIN,
        DONE
    } fb_blit_state_t;

    // Start-of-row frame offset; constant-width multiply reduces to a few adders.
    function automatic logic [FB_AW-1:0] row_offset(input logic [6:0] row,
                                                    input int unsigned width);
        logic [31:0] prod;
        prod = 32'(row) * 32'(width);
        return prod[FB_AW-1:0];
    endfunction

endpackage

// File: rtl/fb_blit_addr_gen.sv
// Pixel walker for fb_blit_sched: i/j counters, incremental ROM/frame row bases,
// last-pixel flag and clear counter. Out-of-frame clip flag when FB_BLIT_CLIP_EN is defined.
module fb_blit_addr_gen #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      load,
    input  logic                      step,
    input  logic                      clr_step,
    input  logic [7:0]                x,
    input  logic [6:0]                y,
    input  logic [5:0]                w,
    input  logic [5:0]                h,
    input  logic [fb_pkg::ROM_AW-1:0] src_base,
    output logic [fb_pkg::ROM_AW-1:0] rom_addr,
    output logic [fb_pkg::FB_AW-1:0]  fb_addr,
    output logic [fb_pkg::FB_AW-1:0]  clr_addr,
    output logic                      last,
    output logic                      clr_last,
    output logic                      clip
);
    import fb_pkg::*;

    localparam logic [FB_AW-1:0] CLR_LAST_ADDR = FB_AW'(FB_W * FB_H - 1);
    localparam logic [FB_AW-1:0] ROW_STEP      = FB_AW'(FB_W);

    logic [7:0]        x_reg;
    logic [6:0]        y_reg;
    logic [5:0]        w_reg;
    logic [5:0]        h_reg;
    logic [5:0]        i_reg;
    logic [5:0]        j_reg;
    logic [ROM_AW-1:0] rom_row_reg;
    logic [FB_AW-1:0]  fb_row_reg;
    logic [FB_AW-1:0]  clr_addr_reg;
    logic              row_end;

    assign row_end = (i_reg == w_reg - 6'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_reg        <= '0;
            y_reg        <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            rom_row_reg  <= '0;
            fb_row_reg   <= '0;
            clr_addr_reg <= '0;
        end else if (load) begin
            x_reg        <= x;
            y_reg        <= y;
            w_reg        <= w;
            h_reg        <= h;
            i_reg        <= '0;
            j_reg        <= '0;
            rom_row_reg  <= src_base;
            fb_row_reg   <= row_offset(y, FB_W);
            clr_addr_reg <= '0;
        end else begin
            if (step) begin
                // Row wrap: both bases advance by one row instead of multiplying j.
                if (row_end) begin
                    i_reg       <= '0;
                    j_reg       <= j_reg + 6'd1;
                    rom_row_reg <= rom_row_reg + ROM_AW'(w_reg);
                    fb_row_reg  <= fb_row_reg + ROW_STEP;
                end else begin
                    i_reg <= i_reg + 6'd1;
                end
            end
            if (clr_step) begin
                clr_addr_reg <= clr_addr_reg + 15'd1;
            end
        end
    end

    logic [8:0] col;
    logic [7:0] row;

    assign col      = {1'b0, x_reg} + {3'b000, i_reg};
    assign row      = {1'b0, y_reg} + {2'b00, j_reg};
    assign rom_addr = rom_row_reg + ROM_AW'(i_reg);
    assign fb_addr  = fb_row_reg + FB_AW'(x_reg) + FB_AW'(i_reg);
    assign clr_addr = clr_addr_reg;
    assign last     = row_end && (j_reg == h_reg - 6'd1);
    assign clr_last = (clr_addr_reg == CLR_LAST_ADDR);

`ifdef FB_BLIT_CLIP_EN
    assign clip = (32'(col) >= FB_W) || (32'(row) >= FB_H);
`else
    assign clip = 1'b0;
`endif

endmodule

// File: rtl/fb_blit_sched.sv
// Frame-buffer write sequencer: full clears and sprite blits become single-pixel writes.
// Optional FB_BLIT_CLIP_EN suppresses writes that fall outside the frame.
module fb_blit_sched #(
    parameter int         FB_W      = fb_pkg::FB_W,
    parameter int         FB_H      = fb_pkg::FB_H,
    parameter logic [4:0] CLEAR_IDX = 5'd8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_clear,
    input  logic [7:0]                req_x,
    input  logic [6:0]                req_y,
    input  logic [5:0]                req_w,
    input  logic [5:0]                req_h,
    input  logic [fb_pkg::ROM_AW-1:0] req_src_base,
    output logic [fb_pkg::ROM_AW-1:0] rom_addr,
    input  logic [fb_pkg::PIX_W-1:0]  rom_data,
    output logic                      fb_we,
    output logic [fb_pkg::FB_AW-1:0]  fb_write_address,
    output logic [fb_pkg::PIX_W-1:0]  fb_data_In,
    output logic                      busy,
    output logic                      done
);
    import fb_pkg::*;

    fb_blit_state_t state_reg;
    fb_blit_state_t state_next;

    logic              accept;
    logic              load;
    logic              step;
    logic              clr_step;
    logic [ROM_AW-1:0] gen_rom_addr;
    logic [FB_AW-1:0]  gen_fb_addr;
    logic [FB_AW-1:0]  gen_clr_addr;
    logic              gen_last;
    logic              gen_clr_last;
    logic              gen_clip;

    logic              wr_valid_reg;
    logic              wr_clip_reg;
    logic [FB_AW-1:0]  wr_addr_reg;

    assign accept = req_valid && req_ready;

    fb_blit_addr_gen #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_addr_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (load),
        .step     (step),
        .clr_step (clr_step),
        .x        (req_x),
        .y        (req_y),
        .w        (req_w),
        .h        (req_h),
        .src_base (req_src_base),
        .rom_addr (gen_rom_addr),
        .fb_addr  (gen_fb_addr),
        .clr_addr (gen_clr_addr),
        .last     (gen_last),
        .clr_last (gen_clr_last),
        .clip     (gen_clip)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        clr_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (req_clear) begin
                        state_next = CLEAR;
                    end else if (req_w == 6'd0 || req_h == 6'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = BLIT;
                    end
                end
            end
            CLEAR: begin
                clr_step = 1'b1;
                if (gen_clr_last) begin
                    state_next = DONE;
                end
            end
            BLIT: begin
                step = 1'b1;
                if (gen_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One-stage write pipeline: ROM data arrives the cycle after its address.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_valid_reg <= 1'b0;
            wr_clip_reg  <= 1'b0;
            wr_addr_reg  <= '0;
        end else begin
            wr_valid_reg <= (state_reg == BLIT);
            wr_clip_reg  <= gen_clip;
            wr_addr_reg  <= gen_fb_addr;
        end
    end

    always_comb begin
        fb_we            = 1'b0;
        fb_write_address = wr_addr_reg;
        fb_data_In       = '0;
        if (state_reg == CLEAR) begin
            fb_we            = 1'b1;
            fb_write_address = gen_clr_addr;
            fb_data_In       = CLEAR_IDX;
        end else if (wr_valid_reg) begin
            // Index 0 is transparent and never written.
            fb_we      = (rom_data != '0) && !wr_clip_reg;
            fb_data_In = rom_data;
        end
    end

    assign req_ready = (state_reg == IDLE) && !Reset;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign rom_addr  = (state_reg == BLIT) ? gen_rom_addr : '0;

endmodule

// File: tb/tb_fb_blit_sched.sv
// Scoreboard bench for fb_blit_sched: expected writes and done cycles are queued by the
// stimulus, a negedge monitor pops and compares. Honours FB_BLIT_CLIP_EN if defined.
module tb_fb_blit_sched;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_clear;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [5:0]  req_w;
    logic [5:0]  req_h;
    logic [15:0] req_src_base;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic        fb_we;
    logic [14:0] fb_write_address;
    logic [4:0]  fb_data_In;
    logic        busy;
    logic        done;

    fb_blit_sched dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_clear        (req_clear),
        .req_x            (req_x),
        .req_y            (req_y),
        .req_w            (req_w),
        .req_h            (req_h),
        .req_src_base     (req_src_base),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .fb_we            (fb_we),
        .fb_write_address (fb_write_address),
        .fb_data_In       (fb_data_In),
        .busy             (busy),
        .done             (done)
    );

    always #5 Clk = ~Clk;

    logic [4:0] rom_mem [0:65535];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [14:0] a;
        logic [4:0]  d;
    } wr_t;

    wr_t wexp[$];
    int  dexp[$];
    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    int  wr_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        chk_cnt++;
        $display("FAIL %s (cyc %0d)", name, cyc);
    endtask

    // Monitor: every write strobe and done pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (fb_we === 1'b1) begin
            wr_seen++;
            if (wexp.size() == 0) begin
                fail($sformatf("unexpected_write addr=%0d data=%0d", fb_write_address, fb_data_In));
            end else begin
                wr_t e;
                e = wexp.pop_front();
                check("wr_addr", 32'(fb_write_address), 32'(e.a));
                check("wr_data", 32'(fb_data_In), 32'(e.d));
            end
        end
        if (done === 1'b1) begin
            if (dexp.size() == 0) fail("unexpected_done");
            else check("done_cycle", cyc, dexp.pop_front());
        end
    end

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.a = 15'(a);
        e.d = 5'(d);
        wexp.push_back(e);
    endtask

    // Issue a command; n_done = cycle index (1 = cycle after accept) of the done pulse.
    task automatic issue(input logic clr, input int x, input int y, input int w, input int h,
                         input int base, input int n_done, output int c0);
        int k;
        @(negedge Clk);
        req_clear    = clr;
        req_x        = 8'(x);
        req_y        = 7'(y);
        req_w        = 6'(w);
        req_h        = 6'(h);
        req_src_base = 16'(base);
        req_valid    = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 50) fail("accept_timeout");
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        c0 = cyc;
        dexp.push_back(c0 + n_done - 1);
        $display("cmd clear=%0d x=%0d y=%0d w=%0d h=%0d base=%0h accepted, done due cyc %0d",
                 clr, x, y, w, h, base, c0 + n_done - 1);
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge Clk);
            #1;
            if (dexp.size() == 0 && busy === 1'b0) begin
                check("wr_queue_drained", 32'(wexp.size()), 32'd0);
                return;
            end
        end
        fail("idle_timeout");
        wexp.delete();
        dexp.delete();
    endtask

    initial begin
        int c0;
        int c1;
        int w0;
        int lim;

        for (int a = 0; a < 65536; a++) rom_mem[a] = 5'((a % 31) + 1);
        rom_mem[16'h100] = 5'd3;
        rom_mem[16'h101] = 5'd0;
        rom_mem[16'h102] = 5'd7;
        rom_mem[16'h103] = 5'd1;

        Reset = 1'b1;
        req_valid = 1'b0;
        req_clear = 1'b0;
        req_x = '0;
        req_y = '0;
        req_w = '0;
        req_h = '0;
        req_src_base = '0;

        // Reset behaviour
        repeat (2) @(posedge Clk);
        #1;
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_fb_addr", 32'(fb_write_address), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // 2x2 blit with a transparent pixel
        push_wr(1050, 3);
        push_wr(1258, 7);
        push_wr(1259, 1);
        issue(1'b0, 10, 5, 2, 2, 16'h100, 6, c0);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check($sformatf("rom_addr_%0d", k), 32'(rom_addr), 32'(16'h100 + k));
        end
        wait_idle(20);

        // Zero-width blit, then re-arm immediately after done
        issue(1'b0, 3, 3, 0, 5, 16'h40, 1, c0);
        @(negedge Clk);
        check("zero_rom_addr", 32'(rom_addr), 32'd0);
        issue(1'b0, 3, 3, 4, 0, 16'h40, 1, c1);
        check("rearm_accept_cycle", c1, c0 + 2);
        wait_idle(10);

        // Right-edge blit: clipped or spilling into the next row
        lim = 4;
`ifdef FB_BLIT_CLIP_EN
        lim = 2;
`endif
        for (int i = 0; i < lim; i++) push_wr(206 + i, int'(rom_mem[16'h300 + i]));
        issue(1'b0, 206, 0, 4, 1, 16'h300, 6, c0);
        wait_idle(20);

        // Full clear
        for (int a = 0; a < 17472; a++) push_wr(a, 8);
        issue(1'b1, 0, 0, 0, 0, 0, 17473, c0);
        wait_idle(18000);

        // 4x4 blit aborted by reset after its third write
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                push_wr(j * 208 + i, int'(rom_mem[16'h200 + j * 4 + i]));
        w0 = wr_seen;
        issue(1'b0, 0, 0, 4, 4, 16'h200, 18, c0);
        req_x = 8'd50;
        req_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            #1;
            if (busy === 1'b1) check("ready_while_busy", 32'(req_ready), 32'd0);
            if (wr_seen >= w0 + 3) break;
        end
        check("writes_before_abort", wr_seen - w0, 3);
        Reset = 1'b1;
        req_valid = 1'b0;
        @(negedge Clk);
        check("abort_fb_we", 32'(fb_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wexp.delete();
        dexp.delete();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("post_abort_writes", wr_seen - w0, 3);
        $display("abort test finished at cyc %0d", cyc);

        check("final_wr_queue", 32'(wexp.size()), 32'd0);
        check("final_done_queue", 32'(dexp.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fb_blit_sched.md
# fb_blit_sched

Write-side sequencer for the 5-bit palette-index frame buffer. It accepts one command at a time: either a full-frame clear, or a rectangular sprite blit from a synchronous sprite ROM. Each command becomes a stream of single-pixel write strobes on the frame buffer write port. It sits between the game-logic draw requester and the frame buffer; the VGA read side is untouched.

## Interface
Parameters:
- FB_W, 208, frame width in pixels
- FB_H, 84, frame height in pixels (FB_W*FB_H = 17472 entries)
- CLEAR_IDX, 5'd8, palette index written by a clear; must be nonzero because the frame buffer drops index-0 writes

Ports:
- Clk  in  1  system clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  1  command present
- req_ready  out  1  block can accept a command; high only in IDLE
- req_clear  in  1  1 = clear frame (other fields ignored), 0 = blit
- req_x  in  8  blit left column
- req_y  in  7  blit top row
- req_w  in  6  blit width in pixels (0..63)
- req_h  in  6  blit height in pixels (0..63)
- req_src_base  in  16  sprite ROM address of the sprite's pixel (0,0); sprite rows are stored row-major, stride req_w
- rom_addr  out  16  sprite ROM read address
- rom_data  in  5  sprite ROM data, valid one cycle after rom_addr
- fb_we  out  1  frame buffer write strobe
- fb_write_address  out  15  frame buffer write address
- fb_data_In  out  5  frame buffer write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready, the block latches all request fields. It then goes to CLEAR if req_clear = 1. It goes to DONE if req_clear = 0 and (req_w == 0 or req_h == 0). Otherwise it goes to BLIT.
  - CLEAR: one write per cycle to addresses 0 through FB_W*FB_H-1 with data CLEAR_IDX. The block goes to DONE after the last address.
  - BLIT: the block walks pixel (i, j), with i the inner index and j the outer, from (0,0) to (w-1, h-1). It issues rom_addr = src_base + j*w + i, using an incremental row base (no multiplier). The frame address is row_base + x + i, where row_base = (y+j)*FB_W is accumulated by adding FB_W per row. After the last ROM read it goes to DRAIN.
  - DRAIN: one cycle that retires the final pipelined pixel, then goes to DONE.
  - DONE: done = 1 for this single cycle, then IDLE.
- Transparency: when rom_data == 0 in the write cycle, fb_we = 0.
- Arithmetic:
  - Frame address is computed at 15 bits, unsigned.
  - ROM address is computed at 16 bits and wraps modulo 2^16.
- Commands are not queued. req_valid while busy is ignored until req_ready returns.

## Timing
- Reset values:
  - State is IDLE.
  - req_ready = 0 during the cycle Reset is high and 1 from the first non-reset cycle.
  - fb_we = 0, busy = 0, done = 0.
  - rom_addr = 0, fb_write_address = 0, fb_data_In = 0.
- Accept at edge E0. The first rom_addr or first clear write is presented in the cycle after E0.
- Blit pipeline: rom_addr for a pixel is presented in cycle k. The write for that pixel (fb_we, address, data) is presented in cycle k+1.
- Cycle counts from the cycle after E0:
  - A blit occupies w*h BLIT cycles plus 1 DRAIN cycle, then DONE.
  - A clear occupies FB_W*FB_H cycles, then DONE.
  - A zero-size blit goes directly to DONE one cycle after E0.
- Reset mid-command aborts immediately; no further writes are issued. Pixels already written remain in the frame buffer.

## Configuration
- FB_BLIT_CLIP_EN defined: the write is suppressed (fb_we = 0) for a pixel with x+i ≥ FB_W or y+j ≥ FB_H. ROM reads proceed unchanged, so the cycle count is unchanged.
- FB_BLIT_CLIP_EN undefined: there is no bounds check. Out-of-row pixels spill into the following row. Addresses beyond FB_W*FB_H-1 are written as computed (15-bit truncation). Keeping requests in bounds is the caller's responsibility.

## Structure
- Package fb_pkg holds:
  - FB_W, FB_H, FB_DEPTH
  - address and index widths (FB_AW = 15, PIX_W = 5, ROM_AW = 16)
  - the state enum fb_blit_state_t {IDLE, CLEAR, BLIT, DRAIN, DONE}
- Sub-module fb_blit_addr_gen holds the i/j counters, the incremental ROM and frame row bases, the last-pixel flag and the clip flag. The top level holds the FSM and the one-stage write pipeline.

## Test plan
- Reset is held for 2 cycles, then released → during reset fb_we = 0, busy = 0, done = 0, req_ready = 0. req_ready = 1 in the first cycle after release.
- Clear command → 17472 consecutive fb_we cycles at addresses 0..17471 with data 8, then a done pulse at cycle 17473 after accept.
- Blit at (10,5), w=2, h=2, base 0x100, with ROM contents {3, 0, 7, 1} → rom_addr sequence 0x100..0x103. Writes are 1050←3, then 1051 skipped (fb_we = 0), then 1258←7, then 1259←1. done occurs 6 cycles after accept.
- Blit at (206,0), w=4, h=1 → with FB_BLIT_CLIP_EN, only addresses 206 and 207 are written. Without it, addresses 206, 207, 208 and 209 are written. Both cases take the same cycle count.
- Blit with w=0 → no rom_addr activity and no fb_we; done pulses one cycle after accept. A new req_valid is accepted in the cycle following done.
- Reset asserted after the third write of a 4x4 blit → fb_we = 0 and busy = 0 from the next cycle. req_valid asserted during the blit is never accepted before req_ready goes high.
